// File: rtl/float_unpack_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : float_unpack_pipe
//  Description : Two-stage multi-lane float unpacker (break + optional
//                subnormal normalisation) with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module float_unpack_pipe #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int LANES     = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [LANES*(EXP_WIDTH+MAN_WIDTH+1)-1:0] in_data,
    input  logic                                  norm_en,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LANES-1:0]                      out_sign,
    output logic [LANES*(EXP_WIDTH+2)-1:0]        out_exp,
    output logic [LANES*(MAN_WIDTH+3)-1:0]        out_man,
    output logic [LANES*3-1:0]                    out_class
);

    localparam int c_float_w = EXP_WIDTH + MAN_WIDTH + 1;
    localparam int c_exp_w   = EXP_WIDTH + 2;
    localparam int c_man_w   = MAN_WIDTH + 3;
    localparam int c_lz_w    = $clog2(MAN_WIDTH + 1);

    localparam logic [2:0] c_cls_zero = 3'd0;
    localparam logic [2:0] c_cls_sub  = 3'd1;
    localparam logic [2:0] c_cls_norm = 3'd2;
    localparam logic [2:0] c_cls_inf  = 3'd3;
    localparam logic [2:0] c_cls_qnan = 3'd4;
    localparam logic [2:0] c_cls_snan = 3'd5;

    logic                       r_v1, r_v2, r_norm1;
    logic [LANES-1:0]           r_sign1, r_sign2;
    logic [LANES*c_exp_w-1:0]   r_exp1, r_exp2;
    logic [LANES*c_man_w-1:0]   r_man1, r_man2;
    logic [LANES*3-1:0]         r_cls1, r_cls2;

    logic [LANES-1:0]           w_s1_sign;
    logic [LANES*c_exp_w-1:0]   w_s1_exp, w_s2_exp;
    logic [LANES*c_man_w-1:0]   w_s1_man, w_s2_man;
    logic [LANES*3-1:0]         w_s1_cls;
    logic                       w_s1_ready, w_s2_ready;

    assign w_s2_ready = !r_v2 || out_ready;
    assign w_s1_ready = !r_v1 || w_s2_ready;
    assign in_ready   = w_s1_ready;

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            logic [c_float_w-1:0] w_f;
            logic [EXP_WIDTH-1:0] w_efield;
            logic [MAN_WIDTH-1:0] w_frac;
            logic                 w_ezero, w_eones, w_fzero;
            logic [MAN_WIDTH-1:0] w_frac1;
            logic [c_man_w-1:0]   w_man1;
            logic [c_lz_w-1:0]    w_lz;
            logic                 w_found;
            logic                 w_do_norm;

            // Break: split fields and classify the raw operand.
            assign w_f      = in_data[i*c_float_w +: c_float_w];
            assign w_efield = w_f[c_float_w-2 -: EXP_WIDTH];
            assign w_frac   = w_f[MAN_WIDTH-1:0];
            assign w_ezero  = (w_efield == '0);
            assign w_eones  = &w_efield;
            assign w_fzero  = (w_frac == '0);

            assign w_s1_sign[i] = w_f[c_float_w-1];
            assign w_s1_exp[i*c_exp_w +: c_exp_w] =
                w_ezero ? c_exp_w'(1) : {2'b00, w_efield};
            assign w_s1_man[i*c_man_w +: c_man_w] = {2'b00, !w_ezero, w_frac};
            assign w_s1_cls[i*3 +: 3] =
                w_ezero ? (w_fzero ? c_cls_zero : c_cls_sub) :
                w_eones ? (w_fzero ? c_cls_inf :
                           (w_frac[MAN_WIDTH-1] ? c_cls_qnan : c_cls_snan)) :
                c_cls_norm;

            // Normalise: shift the subnormal fraction until the hidden bit is set.
            assign w_man1  = r_man1[i*c_man_w +: c_man_w];
            assign w_frac1 = w_man1[MAN_WIDTH-1:0];

            always_comb begin
                w_lz    = '0;
                w_found = 1'b0;
                for (int b = MAN_WIDTH - 1; b >= 0; b--) begin
                    if (!w_found) begin
                        if (w_frac1[b]) w_found = 1'b1;
                        else            w_lz    = w_lz + c_lz_w'(1);
                    end
                end
            end

            assign w_do_norm = r_norm1 && (r_cls1[i*3 +: 3] == c_cls_sub);
            assign w_s2_man[i*c_man_w +: c_man_w] =
                w_do_norm ? (w_man1 << (w_lz + c_lz_w'(1))) : w_man1;
            assign w_s2_exp[i*c_exp_w +: c_exp_w] =
                w_do_norm ? (c_exp_w'(0) - c_exp_w'(w_lz)) : r_exp1[i*c_exp_w +: c_exp_w];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_norm1 <= 1'b0;
            r_sign1 <= '0;
            r_exp1  <= '0;
            r_man1  <= '0;
            r_cls1  <= '0;
        end else if (w_s1_ready) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_norm1 <= norm_en;
                r_sign1 <= w_s1_sign;
                r_exp1  <= w_s1_exp;
                r_man1  <= w_s1_man;
                r_cls1  <= w_s1_cls;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_sign2 <= '0;
            r_exp2  <= '0;
            r_man2  <= '0;
            r_cls2  <= '0;
        end else if (w_s2_ready) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sign2 <= r_sign1;
                r_exp2  <= w_s2_exp;
                r_man2  <= w_s2_man;
                r_cls2  <= r_cls1;
            end
        end
    end

    assign out_valid = r_v2;
    assign out_sign  = r_sign2;
    assign out_exp   = r_exp2;
    assign out_man   = r_man2;
    assign out_class = r_cls2;

endmodule
`default_nettype wire

// File: tb/tb_float_unpack_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_float_unpack_pipe
//  Description : Self-checking bench for float_unpack_pipe (8/23, 4 lanes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_float_unpack_pipe;

    localparam int c_lanes = 4;

    typedef struct packed {
        logic [3:0]   s;
        logic [39:0]  e;
        logic [103:0] m;
        logic [11:0]  c;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  in_data = '0;
    logic          norm_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    out_sign;
    logic [39:0]   out_exp;
    logic [103:0]  out_man;
    logic [11:0]   out_class;
    beat_t         got;

    int checks   = 0;
    int failures = 0;

    assign got = {out_sign, out_exp, out_man, out_class};

    always #5 clk = ~clk;

    float_unpack_pipe #(.EXP_WIDTH(8), .MAN_WIDTH(23), .LANES(c_lanes)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .norm_en(norm_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_man(out_man), .out_class(out_class)
    );

    // Reference: value-level decode, subnormals normalised by doubling.
    function automatic void model_lane(input logic [31:0] f, input logic n,
                                       output logic s, output logic [9:0] e,
                                       output logic [25:0] m, output logic [2:0] c);
        int ef, fr, mm, k;
        ef = int'(f[30:23]);
        fr = int'(f[22:0]);
        s  = f[31];
        if (ef == 0 && fr == 0) begin
            c = 3'd0; e = 10'd1; m = 26'd0;
        end else if (ef == 0) begin
            c = 3'd1;
            if (n) begin
                mm = fr; k = 0;
                while (mm < 8388608) begin mm = mm * 2; k++; end
                e = 10'(1 - k); m = 26'(mm);
            end else begin
                e = 10'd1; m = 26'(fr);
            end
        end else if (ef == 255) begin
            e = 10'(ef); m = 26'(fr + 8388608);
            c = (fr == 0) ? 3'd3 : ((fr >= 4194304) ? 3'd4 : 3'd5);
        end else begin
            c = 3'd2; e = 10'(ef); m = 26'(fr + 8388608);
        end
    endfunction

    function automatic beat_t model(input logic [127:0] d, input logic n);
        beat_t b;
        logic s; logic [9:0] e; logic [25:0] m; logic [2:0] c;
        b = '0;
        for (int i = 0; i < c_lanes; i++) begin
            model_lane(d[i*32 +: 32], n, s, e, m, c);
            b.s[i] = s; b.e[i*10 +: 10] = e; b.m[i*26 +: 26] = m; b.c[i*3 +: 3] = c;
        end
        return b;
    endfunction

    function automatic logic [31:0] rnd_float();
        logic [7:0]  e;
        logic [22:0] fr;
        int sel;
        sel = int'($urandom_range(0, 7));
        fr  = 23'($urandom);
        e   = 8'($urandom);
        case (sel)
            0:       begin e = 8'h00; fr = '0; end
            1, 2:    begin e = 8'h00; fr = fr >> $urandom_range(0, 22); end
            3:       e = 8'hFF;
            4:       begin e = 8'hFF; fr = '0; end
            default: if (e == 8'h00 || e == 8'hFF) e = 8'h80;
        endcase
        return {1'($urandom), e, fr};
    endfunction

    function automatic logic [127:0] rnd_beat();
        logic [127:0] d;
        for (int i = 0; i < c_lanes; i++) d[i*32 +: 32] = rnd_float();
        return d;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || got !== '0) begin
            failures++;
            $display("FAIL reset_state: valid=%b ready=%b out=%h, required valid=0 ready=1 out=0",
                     out_valid, in_ready, got);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] vec  [7] = '{32'h3F800000, 32'h00000001, 32'h00000001, 32'h80000000,
                                  32'h7F800000, 32'h7FC00000, 32'h7F800001};
        logic        nrm  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        xs   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [9:0]  xe   [7] = '{10'h07F, 10'h001, 10'h3EA, 10'h001, 10'h0FF, 10'h0FF, 10'h0FF};
        logic [25:0] xm   [7] = '{26'h0800000, 26'h0000001, 26'h0800000, 26'h0000000,
                                  26'h0800000, 26'h0C00000, 26'h0800001};
        logic [2:0]  xc   [7] = '{3'd2, 3'd1, 3'd1, 3'd0, 3'd3, 3'd4, 3'd5};
        logic [127:0] d;
        beat_t exp_b;
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            d = rnd_beat();
            d[31:0] = vec[v];
            in_valid = 1'b1; in_data = d; norm_en = nrm[v]; out_ready = 1'b1;
            exp_b = model(d, nrm[v]);
            @(negedge clk);
            in_valid = 1'b0; in_data = rnd_beat(); norm_en = ~nrm[v];
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL latency_early[%0d]: out_valid=%b, required 0", v, out_valid);
            end
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_sign[0] !== xs[v] || out_exp[9:0] !== xe[v] ||
                out_man[25:0] !== xm[v] || out_class[2:0] !== xc[v]) begin
                failures++;
                $display("FAIL directed_lane0[%0d]: v=%b s=%b e=%h m=%h c=%0d, required v=1 s=%b e=%h m=%h c=%0d",
                         v, out_valid, out_sign[0], out_exp[9:0], out_man[25:0], out_class[2:0],
                         xs[v], xe[v], xm[v], xc[v]);
            end
            checks++;
            if (got !== exp_b) begin
                failures++;
                $display("FAIL directed_all_lanes[%0d]: got %h, required %h", v, got, exp_b);
            end
        end
    endtask

    task automatic test_back_to_back_backpressure();
        logic [127:0] d [3];
        beat_t exp_b [3];
        int idx, c_pending;
        for (int k = 0; k < 3; k++) begin
            d[k] = rnd_beat();
            exp_b[k] = model(d[k], k[0]);
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            in_valid = 1'b1; in_data = d[k]; norm_en = k[0];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL bp_accept[%0d]: in_ready=%b, required 1", k, in_ready);
            end
        end
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = d[2]; norm_en = 1'b0;
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || got !== exp_b[0]) begin
                failures++;
                $display("FAIL bp_stall[%0d]: ready=%b valid=%b out=%h, required ready=0 valid=1 out=%h",
                         t, in_ready, out_valid, got, exp_b[0]);
            end
        end
        idx = 0; c_pending = 1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (c_pending != 0); in_data = d[2]; norm_en = 1'b0;
            #1;
            if (out_valid) begin
                checks++;
                if (idx > 2) begin
                    failures++;
                    $display("FAIL bp_extra_beat: out=%h, required no beat", got);
                end else if (got !== exp_b[idx]) begin
                    failures++;
                    $display("FAIL bp_order[%0d]: got %h, required %h", idx, got, exp_b[idx]);
                end
                idx++;
            end
            if (in_valid && in_ready) c_pending = 0;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 3) begin
            failures++;
            $display("FAIL bp_count: beats=%0d, required 3", idx);
        end
    endtask

    task automatic test_stream();
        beat_t expq [$];
        beat_t e;
        int sent, rcvd, cyc;
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 1000 && cyc < 20000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = rnd_beat();
            norm_en   = 1'($urandom);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL stream_spurious: out=%h, required no beat", got);
                end else begin
                    e = expq.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL stream_beat[%0d]: got %h, required %h", rcvd, got, e);
                    end
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(in_data, norm_en));
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (rcvd != 1000 || expq.size() != 0) begin
            failures++;
            $display("FAIL stream_count: received=%0d pending=%0d, required 1000 and 0",
                     rcvd, expq.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic [127:0] d;
        beat_t exp_b;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = rnd_beat(); norm_en = 1'b1;
        @(negedge clk);
        in_data = rnd_beat();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midflight_full: valid=%b ready=%b, required valid=1 ready=0",
                     out_valid, in_ready);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || got !== '0) begin
            failures++;
            $display("FAIL midflight_reset: valid=%b ready=%b out=%h, required valid=0 ready=1 out=0",
                     out_valid, in_ready, got);
        end
        @(negedge clk);
        rst = 1'b0;
        d = rnd_beat();
        exp_b = model(d, 1'b1);
        in_valid = 1'b1; in_data = d; norm_en = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ready: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_early: out_valid=%b, required 0", out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || got !== exp_b) begin
            failures++;
            $display("FAIL post_reset_beat: valid=%b out=%h, required valid=1 out=%h",
                     out_valid, got, exp_b);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back_backpressure();
        test_stream();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
